// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter for a shared RAM read/write port
//
// Arbitrates between requester 0 (instruction fill, read only) and requester 1
// (data fill or writeback) for a single RAM r/w port.
// One transaction at a time is sequenced through IDLE -> ISSUE -> WAIT -> RESP.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req0/req1             requests, held until the matching ack
//   we0/we1               line-write flags (we0 is ignored)
//   addr0/addr1           line addresses
//   din1                  write line from requester 1
//   ack0/ack1             one-cycle completion pulses
//   dout0/dout1           read lines, held until the next ack to that requester
//   ram_addr/ram_din      RAM port address / write data
//   ram_read/ram_write    RAM port one-cycle command strobes
//   ram_state/ram_dout    RAM port status and read data
//   busy                  high whenever not IDLE
//   owner                 current or last granted requester
//   grants0/grants1       saturating completed-transaction counters

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 16
`endif
`ifndef CACHE_LINE_WIDTH
`define CACHE_LINE_WIDTH 64
`endif
`ifndef RAM_PORT_STATE_WIDTH
`define RAM_PORT_STATE_WIDTH 3
`endif

module ram_port_arbiter #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req0,
    input  logic                             req1,
    input  logic                             we0,
    input  logic                             we1,
    input  logic [`PHYSICAL_ADDR_WIDTH-1:0]  addr0,
    input  logic [`PHYSICAL_ADDR_WIDTH-1:0]  addr1,
    input  logic [`CACHE_LINE_WIDTH-1:0]     din1,
    output logic                             ack0,
    output logic                             ack1,
    output logic [`CACHE_LINE_WIDTH-1:0]     dout0,
    output logic [`CACHE_LINE_WIDTH-1:0]     dout1,
    output logic [`PHYSICAL_ADDR_WIDTH-1:0]  ram_addr,
    output logic [`CACHE_LINE_WIDTH-1:0]     ram_din,
    output logic                             ram_read,
    output logic                             ram_write,
    input  logic [`RAM_PORT_STATE_WIDTH-1:0] ram_state,
    input  logic [`CACHE_LINE_WIDTH-1:0]     ram_dout,
    output logic                             busy,
    output logic                             owner,
    output logic [31:0]                      grants0,
    output logic [31:0]                      grants1
);

    localparam int AW = `PHYSICAL_ADDR_WIDTH;
    localparam int LW = `CACHE_LINE_WIDTH;
    localparam int SW = `RAM_PORT_STATE_WIDTH;

    localparam logic [SW-1:0] RS_NONE         = SW'(0);
    localparam logic [SW-1:0] RS_DONE_READING = SW'(3);
    localparam logic [SW-1:0] RS_DONE_WRITING = SW'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [LW-1:0]   din_q, din_d;
    logic            first_wait_q, first_wait_d;
    logic [LW-1:0]   dout0_q, dout0_d;
    logic [LW-1:0]   dout1_q, dout1_d;
    logic [31:0]     grants0_q, grants0_d;
    logic [31:0]     grants1_q, grants1_d;

    logic            ram_ready;
    logic            ram_done;
    logic            winner;

    // The RAM is never reset with us, so a fresh issue waits for it to be
    // quiescent or finished rather than trusting our own IDLE state.
    assign ram_ready = (ram_state == RS_NONE) || ram_done;
    assign ram_done  = (ram_state == RS_DONE_READING) || (ram_state == RS_DONE_WRITING);

    always_comb begin
        winner = req1;
        if (req0 && req1) begin
            winner = (FIXED_PRIORITY != 0) ? 1'b1 : ~owner_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        we_d         = we_q;
        din_d        = din_q;
        first_wait_d = first_wait_q;
        dout0_d      = dout0_q;
        dout1_d      = dout1_q;
        grants0_d    = grants0_q;
        grants1_d    = grants1_q;

        case (state_q)
            S_IDLE: begin
                if ((req0 || req1) && ram_ready) begin
                    owner_d = winner;
                    addr_d  = winner ? addr1 : addr0;
                    we_d    = winner & we1;
                    din_d   = winner ? din1 : '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                first_wait_d = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                // The RAM may still report the previous DONE on the first
                // cycle after the strobe, so that cycle is not trusted.
                first_wait_d = 1'b0;
                if (!first_wait_q && ram_done) begin
                    if (!we_q) begin
                        if (owner_q) begin
                            dout1_d = ram_dout;
                        end else begin
                            dout0_d = ram_dout;
                        end
                    end
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (owner_q) begin
                    if (grants1_q != '1) grants1_d = grants1_q + 32'd1;
                end else begin
                    if (grants0_q != '1) grants0_d = grants0_q + 32'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            din_q        <= '0;
            first_wait_q <= 1'b0;
            dout0_q      <= '0;
            dout1_q      <= '0;
            grants0_q    <= '0;
            grants1_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            din_q        <= din_d;
            first_wait_q <= first_wait_d;
            dout0_q      <= dout0_d;
            dout1_q      <= dout1_d;
            grants0_q    <= grants0_d;
            grants1_q    <= grants1_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign ram_read  = (state_q == S_ISSUE) && !we_q;
    assign ram_write = (state_q == S_ISSUE) && we_q;
    assign ram_addr  = busy ? addr_q : '0;
    assign ram_din   = busy ? din_q : '0;
    assign ack0      = (state_q == S_RESP) && !owner_q;
    assign ack1      = (state_q == S_RESP) && owner_q;
    assign dout0     = dout0_q;
    assign dout1     = dout1_q;
    assign owner     = owner_q;
    assign grants0   = grants0_q;
    assign grants1   = grants1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter

`timescale 1ns/1ps

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 16
`endif
`ifndef CACHE_LINE_WIDTH
`define CACHE_LINE_WIDTH 64
`endif
`ifndef RAM_PORT_STATE_WIDTH
`define RAM_PORT_STATE_WIDTH 3
`endif

module tb_ram_port_arbiter;

    localparam int AW        = `PHYSICAL_ADDR_WIDTH;
    localparam int LW        = `CACHE_LINE_WIDTH;
    localparam int SW        = `RAM_PORT_STATE_WIDTH;
    localparam int RAM_DELAY = 10;

    localparam logic [SW-1:0] RS_NONE   = SW'(0);
    localparam logic [SW-1:0] RS_RD     = SW'(1);
    localparam logic [SW-1:0] RS_WR     = SW'(2);
    localparam logic [SW-1:0] RS_DONE_R = SW'(3);
    localparam logic [SW-1:0] RS_DONE_W = SW'(4);

    logic          clk;
    logic [1:0]    reset, req0, req1, we0, we1, ack0, ack1;
    logic [1:0]    ram_read, ram_write, busy, owner, ram_rst;
    logic [AW-1:0] addr0 [2];
    logic [AW-1:0] addr1 [2];
    logic [AW-1:0] ram_addr [2];
    logic [LW-1:0] din1 [2];
    logic [LW-1:0] dout0 [2];
    logic [LW-1:0] dout1 [2];
    logic [LW-1:0] ram_din [2];
    logic [LW-1:0] ram_dout [2];
    logic [SW-1:0] ram_state [2];
    logic [31:0]   grants0 [2];
    logic [31:0]   grants1 [2];

    // RAM model storage and bench-side reference memory
    logic [LW-1:0] mem [2][256];
    logic [LW-1:0] ref_mem [2][256];
    logic [7:0]    pend_a [2];
    logic [LW-1:0] pend_d [2];
    int            ram_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_g0 [2];
    int exp_g1 [2];

    typedef struct {
        int            inst;
        logic          r0, r1, w0, w1;
        logic [AW-1:0] a0, a1;
        logic [LW-1:0] d1;
        logic          first;
    } vec_t;

    vec_t tbl [11];

    ram_port_arbiter #(.FIXED_PRIORITY(0)) u_rr (
        .clk(clk), .reset(reset[0]), .req0(req0[0]), .req1(req1[0]),
        .we0(we0[0]), .we1(we1[0]), .addr0(addr0[0]), .addr1(addr1[0]),
        .din1(din1[0]), .ack0(ack0[0]), .ack1(ack1[0]), .dout0(dout0[0]),
        .dout1(dout1[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
        .ram_read(ram_read[0]), .ram_write(ram_write[0]), .ram_state(ram_state[0]),
        .ram_dout(ram_dout[0]), .busy(busy[0]), .owner(owner[0]),
        .grants0(grants0[0]), .grants1(grants1[0])
    );

    ram_port_arbiter #(.FIXED_PRIORITY(1)) u_fix (
        .clk(clk), .reset(reset[1]), .req0(req0[1]), .req1(req1[1]),
        .we0(we0[1]), .we1(we1[1]), .addr0(addr0[1]), .addr1(addr1[1]),
        .din1(din1[1]), .ack0(ack0[1]), .ack1(ack1[1]), .dout0(dout0[1]),
        .dout1(dout1[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
        .ram_read(ram_read[1]), .ram_write(ram_write[1]), .ram_state(ram_state[1]),
        .ram_dout(ram_dout[1]), .busy(busy[1]), .owner(owner[1]),
        .grants0(grants0[1]), .grants1(grants1[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LW-1:0] line_init(input logic [7:0] a);
        return {24'hC0DE00, a, 24'h5A5A00, ~a};
    endfunction

    // RAM model: command seen at the clock edge ending the ISSUE cycle, then
    // busy for RAM_DELAY+1 cycles, then DONE until the next command.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (ram_rst[g]) begin
                for (int a = 0; a < 256; a++) mem[g][a] <= line_init(8'(a));
                ram_state[g] <= RS_NONE;
                ram_dout[g]  <= '0;
                ram_cnt[g]   <= 0;
            end else if (ram_write[g]) begin
                ram_state[g] <= RS_WR;
                ram_cnt[g]   <= RAM_DELAY;
                pend_a[g]    <= ram_addr[g][7:0];
                pend_d[g]    <= ram_din[g];
            end else if (ram_read[g]) begin
                ram_state[g] <= RS_RD;
                ram_cnt[g]   <= RAM_DELAY;
                pend_a[g]    <= ram_addr[g][7:0];
            end else if (ram_state[g] == RS_RD || ram_state[g] == RS_WR) begin
                if (ram_cnt[g] == 0) begin
                    if (ram_state[g] == RS_WR) begin
                        mem[g][pend_a[g]] <= pend_d[g];
                        ram_state[g]      <= RS_DONE_W;
                    end else begin
                        ram_dout[g]  <= mem[g][pend_a[g]];
                        ram_state[g] <= RS_DONE_R;
                    end
                end else begin
                    ram_cnt[g] <= ram_cnt[g] - 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic r0, input logic r1,
                                input logic w0, input logic w1,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [LW-1:0] d1, input logic first);
        vec_t v;
        v.inst = inst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d1 = d1; v.first = first;
        return v;
    endfunction

    task automatic reset_inst(input int i);
        @(posedge clk); #1;
        reset[i] = 1'b1;
        req0[i] = 1'b0; req1[i] = 1'b0;
        @(posedge clk); #1;
        reset[i] = 1'b0;
        exp_g0[i] = 0; exp_g1[i] = 0;
    endtask

    // One round: raise the listed requests together in an IDLE cycle, then
    // serve them all; each served requester drops req the cycle after ack.
    task automatic run_round(input vec_t v);
        int i, nexp, nserved, nissue, t_ref;
        logic cur, drop0, drop1, exp_wr;
        logic [AW-1:0] exp_a;
        logic [LW-1:0] exp_d, got;
        i = v.inst;
        nexp = int'(v.r0) + int'(v.r1);
        nserved = 0; nissue = 0; t_ref = 0; drop0 = 1'b0; drop1 = 1'b0;
        for (int k = 0; k < 400 && nserved < nexp; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                req0[i] = v.r0; req1[i] = v.r1; we0[i] = v.w0; we1[i] = v.w1;
                addr0[i] = v.a0; addr1[i] = v.a1; din1[i] = v.d1;
            end
            if (drop0) begin req0[i] = 1'b0; drop0 = 1'b0; end
            if (drop1) begin req1[i] = 1'b0; drop1 = 1'b0; end
            @(negedge clk);
            cur    = (nserved == 0) ? v.first : ~v.first;
            exp_wr = cur & v.w1;
            exp_a  = cur ? v.a1 : v.a0;
            exp_d  = cur ? v.d1 : '0;
            if (ram_read[i] | ram_write[i]) begin
                nissue++;
                check("issue_cycle", 64'(k), 64'(t_ref + 1));
                check("ram_write", 64'(ram_write[i]), 64'(exp_wr));
                check("ram_read", 64'(ram_read[i]), 64'(!exp_wr));
                check("ram_addr", 64'(ram_addr[i]), 64'(exp_a));
                check("ram_din", ram_din[i], exp_d);
            end
            if (ack0[i] | ack1[i]) begin
                check("ack_exclusive", 64'(ack0[i] & ack1[i]), 64'(0));
                check("ack_who", 64'(ack1[i]), 64'(cur));
                check("owner", 64'(owner[i]), 64'(cur));
                check("ack_latency", 64'(k), 64'(t_ref + RAM_DELAY + 4));
                if (!exp_wr) begin
                    got = cur ? dout1[i] : dout0[i];
                    check("dout", got, ref_mem[i][exp_a[7:0]]);
                end else begin
                    ref_mem[i][exp_a[7:0]] = exp_d;
                end
                if (cur) begin exp_g1[i]++; drop1 = 1'b1; end
                else begin exp_g0[i]++; drop0 = 1'b1; end
                nserved++;
                t_ref = k + 1;
            end
        end
        check("round_served", 64'(nserved), 64'(nexp));
        check("round_issues", 64'(nissue), 64'(nexp));
        @(posedge clk); #1;
        req0[i] = 1'b0; req1[i] = 1'b0;
        @(negedge clk);
        check("busy_after_round", 64'(busy[i]), 64'(0));
        check("grants0", 64'(grants0[i]), 64'(exp_g0[i]));
        check("grants1", 64'(grants1[i]), 64'(exp_g1[i]));
    endtask

    // addr0 changes the cycle after grant; the latched address must persist.
    task automatic addr_hold();
        int got_ack;
        got_ack = 0;
        @(posedge clk); #1;
        req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 16'h40; req1[0] = 1'b0;
        @(negedge clk);
        check("idle_ram_addr", 64'(ram_addr[0]), 64'(0));
        check("idle_ram_din", ram_din[0], 64'(0));
        for (int k = 1; k < 60 && got_ack == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) addr0[0] = 16'hC0;
            @(negedge clk);
            if (busy[0]) check("addr_hold", 64'(ram_addr[0]), 64'h40);
            if (ack0[0]) begin
                got_ack = 1;
                check("addr_hold_dout", dout0[0], ref_mem[0][8'h40]);
                exp_g0[0]++;
            end
        end
        check("addr_hold_ack", 64'(got_ack), 64'(1));
        @(posedge clk); #1;
        req0[0] = 1'b0;
    endtask

    // Both requesters continuously requesting, re-raising one cycle after drop.
    task automatic rr_continuous();
        int nacks, pend0, pend1;
        logic who;
        reset_inst(0);
        nacks = 0; pend0 = 0; pend1 = 0;
        req0[0] = 1'b1; req1[0] = 1'b1; we0[0] = 1'b0; we1[0] = 1'b0;
        addr0[0] = 16'h20; addr1[0] = 16'h30;
        for (int k = 0; k < 400 && nacks < 4; k++) begin
            @(posedge clk); #1;
            if (pend0 == 2) begin req0[0] = 1'b0; pend0 = 1; end
            else if (pend0 == 1) begin req0[0] = 1'b1; pend0 = 0; end
            if (pend1 == 2) begin req1[0] = 1'b0; pend1 = 1; end
            else if (pend1 == 1) begin req1[0] = 1'b1; pend1 = 0; end
            @(negedge clk);
            check("rr_ack_exclusive", 64'(ack0[0] & ack1[0]), 64'(0));
            if (ack0[0] | ack1[0]) begin
                who = ack1[0];
                check("rr_order", 64'(who), 64'(nacks % 2));
                check("rr_owner", 64'(owner[0]), 64'(who));
                if (who) begin pend1 = 2; exp_g1[0]++; end
                else begin pend0 = 2; exp_g0[0]++; end
                nacks++;
            end
        end
        check("rr_acks", 64'(nacks), 64'(4));
        @(posedge clk); #1;
        req0[0] = 1'b0; req1[0] = 1'b0;
        @(negedge clk);
        check("rr_grants0", 64'(grants0[0]), 64'(exp_g0[0]));
        check("rr_grants1", 64'(grants1[0]), 64'(exp_g1[0]));
    endtask

    // Reset during WAIT: no ack, and the next issue waits for the RAM's DONE.
    task automatic reset_abort();
        int issue_k, done_k, ack_k, early;
        issue_k = -1; done_k = -1; ack_k = -1; early = 0;
        for (int k = 0; k < 80 && ack_k < 0; k++) begin
            @(posedge clk); #1;
            case (k)
                0: begin req0[0] = 1'b1; we0[0] = 1'b0; addr0[0] = 16'h20; end
                5: begin reset[0] = 1'b1; req0[0] = 1'b0; end
                6: reset[0] = 1'b0;
                8: begin req0[0] = 1'b1; addr0[0] = 16'h30; end
                default: ;
            endcase
            @(negedge clk);
            if (k == 6) begin
                check("abort_busy", 64'(busy[0]), 64'(0));
                check("abort_owner", 64'(owner[0]), 64'(1));
                check("abort_grants0", 64'(grants0[0]), 64'(0));
                check("abort_dout0", dout0[0], 64'(0));
                check("abort_ram_read", 64'(ram_read[0]), 64'(0));
                exp_g0[0] = 0; exp_g1[0] = 0;
            end
            if (k > 6 && done_k < 0 && ram_state[0] == RS_DONE_R) done_k = k;
            if (k > 6 && issue_k < 0 && (ram_read[0] | ram_write[0])) issue_k = k;
            if (ack0[0] | ack1[0]) begin
                if (issue_k < 0 || ack1[0]) early++;
                else begin
                    ack_k = k;
                    check("reissue_dout0", dout0[0], ref_mem[0][8'h30]);
                    exp_g0[0]++;
                end
            end
        end
        check("abort_early_ack", 64'(early), 64'(0));
        check("ram_done_cycle", 64'(done_k), 64'(13));
        check("reissue_after_done", 64'(issue_k), 64'(done_k + 1));
        check("reissue_ack_latency", 64'(ack_k), 64'(issue_k + RAM_DELAY + 3));
        @(posedge clk); #1;
        req0[0] = 1'b0;
        @(negedge clk);
        check("reissue_grants0", 64'(grants0[0]), 64'(exp_g0[0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 2'b11; ram_rst = 2'b11;
        req0 = '0; req1 = '0; we0 = '0; we1 = '0;
        for (int g = 0; g < 2; g++) begin
            addr0[g] = '0; addr1[g] = '0; din1[g] = '0;
            exp_g0[g] = 0; exp_g1[g] = 0;
            for (int a = 0; a < 256; a++) ref_mem[g][a] = line_init(8'(a));
        end

        tbl[0]  = mk(0, 1, 0, 0, 0, 16'h40, 16'h00, 64'h0,    1'b0);
        tbl[1]  = mk(0, 0, 1, 0, 0, 16'h00, 16'h10, 64'h0,    1'b1);
        tbl[2]  = mk(0, 1, 1, 0, 0, 16'h20, 16'h30, 64'h0,    1'b0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 16'h50, 16'h00, 64'h0,    1'b0);
        tbl[4]  = mk(0, 1, 1, 0, 0, 16'h60, 16'h70, 64'h0,    1'b1);
        tbl[5]  = mk(0, 0, 1, 0, 1, 16'h00, 16'h80, 64'hA5,   1'b1);
        tbl[6]  = mk(0, 1, 0, 1, 0, 16'h80, 16'h00, 64'h0,    1'b0);
        tbl[7]  = mk(1, 1, 1, 0, 0, 16'h11, 16'h22, 64'h0,    1'b1);
        tbl[8]  = mk(1, 0, 1, 0, 0, 16'h00, 16'h33, 64'h0,    1'b1);
        tbl[9]  = mk(1, 1, 1, 0, 1, 16'h44, 16'h55, 64'h1234, 1'b1);
        tbl[10] = mk(1, 1, 1, 0, 0, 16'h55, 16'h66, 64'h0,    1'b1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_ram_read", 64'(ram_read[g]), 64'(0));
            check("rst_ram_write", 64'(ram_write[g]), 64'(0));
            check("rst_ram_addr", 64'(ram_addr[g]), 64'(0));
            check("rst_ram_din", ram_din[g], 64'(0));
            check("rst_ack0", 64'(ack0[g]), 64'(0));
            check("rst_ack1", 64'(ack1[g]), 64'(0));
            check("rst_dout0", dout0[g], 64'(0));
            check("rst_dout1", dout1[g], 64'(0));
            check("rst_owner", 64'(owner[g]), 64'(1));
            check("rst_grants0", 64'(grants0[g]), 64'(0));
            check("rst_grants1", 64'(grants1[g]), 64'(0));
            check("rst_busy", 64'(busy[g]), 64'(0));
        end
        @(posedge clk); #1;
        reset = 2'b00; ram_rst = 2'b00;

        for (int r = 0; r < 11; r++) run_round(tbl[r]);

        addr_hold();
        rr_continuous();
        reset_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: ports clk and reset, all state updated only on posedge clk.
REQ-002 Parameter FIXED_PRIORITY SHALL default to 0: 0 = round-robin between requesters, 1 = requester 1 always wins ties.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req0 / req1  input  1  request from requester 0 (instruction fill) / requester 1 (data fill or writeback), held high until the matching ack.
REQ-006 we0 / we1  input  1  request is a line write; we0 SHALL be ignored and treated as 0.
REQ-007 addr0 / addr1  input  `PHYSICAL_ADDR_WIDTH  line address of the request.
REQ-008 din1  input  `CACHE_LINE_WIDTH  write line for requester 1.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse.
REQ-010 dout0 / dout1  output  `CACHE_LINE_WIDTH  read line, valid while ack is high and held until the next ack to the same requester.
REQ-011 ram_addr  output  `PHYSICAL_ADDR_WIDTH  address to the RAM r/w port.
REQ-012 ram_din  output  `CACHE_LINE_WIDTH  write data to the RAM r/w port.
REQ-013 ram_read / ram_write  output  1  RAM r/w port read and write enables.
REQ-014 ram_state  input  `RAM_PORT_STATE_WIDTH  RAM r/w port state: NONE=0, READING=1, WRITING=2, DONE_READING=3, DONE_WRITING=4.
REQ-015 ram_dout  input  `CACHE_LINE_WIDTH  RAM r/w port read data.
REQ-016 busy  output  1  high in every state other than IDLE.
REQ-017 owner  output  1  index of the current or last granted requester.
REQ-018 grants0 / grants1  output  32  count of completed transactions per requester.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: the block SHALL grant only if (req0|req1) is high and ram_state is NONE, DONE_READING or DONE_WRITING; otherwise it stays in IDLE.
REQ-021 On grant, the block SHALL latch the winner's addr, we and din (din=0 for requester 0), set owner, and go to ISSUE.
REQ-022 Tie, round-robin: the winner SHALL be the requester other than owner.
REQ-023 Tie, FIXED_PRIORITY=1: the winner SHALL be requester 1.
REQ-024 A single active request SHALL always win.
REQ-025 ISSUE: ram_read = !we_latched and ram_write = we_latched SHALL be high for exactly this one cycle; next state WAIT.
REQ-026 ram_addr and ram_din SHALL drive the latched values in ISSUE, WAIT and RESP, and 0 in IDLE.
REQ-027 ram_read and ram_write SHALL be 0 in every state other than ISSUE, and SHALL never be high together.
REQ-028 WAIT: the block SHALL ignore the first WAIT cycle's ram_state.
REQ-029 WAIT, from the second cycle: on DONE_READING or DONE_WRITING, the block SHALL capture ram_dout (reads only) into dout[owner] and go to RESP.
REQ-030 RESP: ack[owner] SHALL be high for exactly one cycle, grants[owner] SHALL increment (saturating at 2^32-1), and the next state SHALL be IDLE.
REQ-031 Requesters SHALL deassert req in the cycle after ack; a req still high in IDLE SHALL be treated as a new request.
REQ-032 Latency: with RAM DELAY=D, req first seen high in idle cycle t SHALL produce ack in cycle t+D+4 (t+14 for D=10).
REQ-033 Requests arriving while busy SHALL wait; no request SHALL be dropped or reordered within one requester.
REQ-034 Changes to addr, we or din after grant SHALL have no effect on the transaction in progress.
REQ-035 An unexpected ram_state of 0 during WAIT SHALL keep the block in WAIT.

Reset
REQ-036 On reset: state IDLE, ram_read=ram_write=0, ram_addr=ram_din=0, ack0=ack1=0, dout0=dout1=0, owner=1 (requester 0 wins the first tie), grants0=grants1=0, busy=0.
REQ-037 Reset mid-transaction SHALL abort without an ack; because the RAM is not reset, REQ-020 alone SHALL hold off the next issue until the RAM port reaches a DONE state.

Verification
REQ-038 req0 high at cycle 0, addr0=0x40, RAM DELAY=10 -> single ram_read pulse at cycle 1 with ram_addr=0x40; ack0 at cycle 14 with dout0 equal to RAM line 0x40; grants0=1.
REQ-039 req0 and req1 both high from reset, round-robin -> order of service is 0, 1, 0, 1; ack0 and ack1 never high in the same cycle; owner alternates.
REQ-040 Same stimulus with FIXED_PRIORITY=1 -> requester 1 served every time both are high; requester 0 served only when req1 is low.
REQ-041 req1 with we1=1, addr1=0x80, din1=0xA5 repeated -> single ram_write pulse; ack1 after DONE_WRITING; a subsequent req0 read of 0x80 returns the written line.
REQ-042 reset asserted during WAIT of a read -> no ack; a req0 during the RAM's remaining READING cycles is issued only after ram_state becomes DONE_READING.
REQ-043 addr0 changed to 0xC0 in the cycle after grant of addr 0x40 -> ram_addr stays 0x40 through RESP.
